// File: rtl/sn151_scanner.sv
// Sequencer for an SN74XX151 8-to-1 mux: steps sel/str, samples the mux output and assembles a byte.
// Optional complement check of mux_nout against mux_out is enabled with `define SN151_SCANNER_CHECK_EN.
module sn151_scanner #(
    parameter int SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] data,
    output logic [2:0] sel,
    output logic       str,
    input  logic       mux_out,
    input  logic       mux_nout,
    output logic       err
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE);

    state_t     state;
    logic [3:0] cnt;
    logic [6:0] cap;    // bit 7 never needs storing; it goes straight from mux_out into data

`ifndef SN151_SCANNER_CHECK_EN
    logic unused_nout;
    assign unused_nout = mux_nout;
    assign err         = 1'b0;
`endif

    // NOTE: every register here, including the capture byte, is plain flops, so all of it is
    // reset and all of it is updated with non-blocking assignments from this one process.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 3'd0;
            str   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            data  <= 8'h00;
            cnt   <= 4'd0;
            cap   <= 7'd0;
`ifdef SN151_SCANNER_CHECK_EN
            err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        sel   <= 3'd0;
                        str   <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= RELOAD;
                        cap   <= 7'd0;
                    end
                end
                SCAN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
`ifdef SN151_SCANNER_CHECK_EN
                        if (mux_nout == mux_out)
                            err <= 1'b1;
`endif
                        if (sel != 3'd7) begin
                            cap[sel] <= mux_out;
                            sel      <= sel + 3'd1;
                            cnt      <= RELOAD;
                        end else begin
                            data <= {mux_out, cap};
                            done <= 1'b1;
                            sel  <= 3'd0;
                            cnt  <= RELOAD;
                            cap  <= 7'd0;
                            // A start present on the final capture chains the next scan with no idle gap.
                            if (start) begin
                                busy <= 1'b1;
                                str  <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                str   <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sn151_scanner.sv
// Self-checking bench for sn151_scanner: two instances (SETTLE=0 and SETTLE=3) each read an SN74XX151 model.
// Expectations come from scan arithmetic: select k is presented for SETTLE+1 cycles, done after 8*(SETTLE+1).
module tb_sn151_scanner;

`ifdef SN151_SCANNER_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start0, start3;
    logic       busy0, busy3, done0, done3, str0, str3, err0, err3;
    logic [7:0] data0, data3;
    logic [2:0] sel0, sel3;
    logic       mux_out0, mux_out3, mux_nout0, mux_nout3;
    logic [7:0] a0, a3;
    logic       bad;
    logic       exp_err;

    int n_pass  = 0;
    int n_total = 0;

    // SN74XX151 models: Y = 0 while strobe is high, W is the complement unless the bench corrupts it.
    assign mux_out0  = str0 ? 1'b0 : a0[sel0];
    assign mux_nout0 = (bad && sel0 == 3'd2) ? mux_out0 : ~mux_out0;
    assign mux_out3  = str3 ? 1'b0 : a3[sel3];
    assign mux_nout3 = ~mux_out3;

    sn151_scanner #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .data(data0),
        .sel(sel0), .str(str0), .mux_out(mux_out0), .mux_nout(mux_nout0), .err(err0)
    );

    sn151_scanner #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .data(data3),
        .sel(sel3), .str(str3), .mux_out(mux_out3), .mux_nout(mux_nout3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One start pulse, then the whole scan is checked cycle by cycle against the timing arithmetic.
    task automatic do_scan(input bit inst, input logic [7:0] val);
        int s = inst ? 3 : 0;
        int n = 8 * (s + 1);
        if (inst) a3 = val; else a0 = val;
        if (inst) start3 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
        for (int j = 0; j < n; j++) begin
            check("scan_sel",  inst ? sel3  : sel0,  32'(j / (s + 1)));
            check("scan_str",  inst ? str3  : str0,  32'd0);
            check("scan_busy", inst ? busy3 : busy0, 32'd1);
            check("scan_done", inst ? done3 : done0, 32'd0);
            @(negedge clk);
        end
        check("end_done", inst ? done3 : done0, 32'd1);
        check("end_data", inst ? data3 : data0, 32'(val));
        check("end_busy", inst ? busy3 : busy0, 32'd0);
        check("end_str",  inst ? str3  : str0,  32'd1);
        check("end_sel",  inst ? sel3  : sel0,  32'd0);
        check("end_err",  inst ? err3  : err0,  inst ? 32'd0 : 32'(exp_err));
        @(negedge clk);
        check("post_done", inst ? done3 : done0, 32'd0);
        check("post_data", inst ? data3 : data0, 32'(val));
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1; start0 = 1'b0; start3 = 1'b0; a0 = 8'h00; a3 = 8'h00; bad = 1'b0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy0, 32'd0);
        check("rst_done", done0, 32'd0);
        check("rst_data", data0, 32'd0);
        check("rst_str",  str0,  32'd1);
        check("rst_sel",  sel0,  32'd0);
        check("rst_err",  err0,  32'd0);
        check("rst_data3", data3, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Default scan and settle stretch.
        do_scan(1'b0, 8'hA5);
        do_scan(1'b1, 8'h3C);

        // Handshake: mid-scan start ignored, start in the done cycle accepted, held start chains scans.
        a0 = 8'h81;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("hs_busy", busy0, 32'd1);
            check("hs_done", done0, 32'd0);
            start0 = (j == 4);
            @(negedge clk);
        end
        start0 = 1'b0;
        check("hs_done_at_8", done0, 32'd1);
        check("hs_data", data0, 32'h81);
        start0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 16; k++) begin
            check("hs_chain_done", done0, (k == 8 || k == 16) ? 32'd1 : 32'd0);
            check("hs_chain_busy", busy0, (k < 16) ? 32'd1 : 32'd0);
            check("hs_chain_sel",  sel0, (k < 16) ? 32'(k % 8) : 32'd0);
            if (k == 8 || k == 16) check("hs_chain_data", data0, 32'h81);
            if (k == 15) start0 = 1'b0;
            if (k < 16) @(negedge clk);
        end
        @(negedge clk);
        check("hs_idle_done", done0, 32'd0);
        check("hs_idle_busy", busy0, 32'd0);

        // Reset in the middle of a scan.
        a0 = 8'hFF;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_sel5", sel0, 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_sel",  sel0,  32'd0);
        check("mid_str",  str0,  32'd1);
        check("mid_busy", busy0, 32'd0);
        check("mid_data", data0, 32'd0);
        check("mid_done", done0, 32'd0);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("mid_no_done", done0, 32'd0);
        end
        do_scan(1'b0, 8'hFF);

        // Randomized scans on both instances.
        for (int r = 0; r < 8; r++) begin
            v = 8'($urandom);
            do_scan(r[0], v);
        end

        // Complement check: mux_nout corrupted while sel=2.
        v = 8'($urandom);
        a0 = v;
        bad = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("chk_err", err0, (CHECK_ON && j >= 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check("chk_done", done0, 32'd1);
        check("chk_data", data0, 32'(v));
        check("chk_err_end", err0, 32'(CHECK_ON));
        bad = 1'b0;
        exp_err = CHECK_ON;
        @(negedge clk);
        do_scan(1'b0, 8'($urandom));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        check("chk_err_rst", err0, 32'd0);
        do_scan(1'b0, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
